// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard detection and forwarding control.
//
// Keeps a shadow copy of the destination/control fields of the EX, MEM and
// WB stages. From that state and the instruction in ID it derives the
// stall, bubble, flush and operand-forwarding controls. It also counts the
// cycles in which the PC was held.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   id_opcode       opcode of the instruction in ID
//   id_rs/rt/rd     register fields of the instruction in ID
//   br_taken        beq comparison result (meaningful only for beq)
//   mem_busy        data memory not ready; freezes the whole pipeline
//   pc_write        1 = PC may update
//   ifid_write      1 = IF/ID may load
//   ifid_flush      1 = IF/ID loads a bubble (taken branch)
//   idex_bubble     1 = ID/EX loads all-zero control
//   fwd_a, fwd_b    EX operand source: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall_count     saturating count of cycles with pc_write=0
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  id_opcode,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_count
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_ANDI  = 6'b001100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_t;

    typedef struct packed {
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } stage_t;

    stage_t     ex_st, mem_st, wb_st;
    logic [4:0] ex_rs, ex_rt;

    stage_t     id_st;
    logic [4:0] id_src_rs, id_src_rt;
    logic       id_beq;
    logic       load_use, br_hazard;

    // Register $0 is never a real producer, so it never matches.
    function automatic logic hits(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input stage_t    m,
                                           input stage_t    w);
        if (m.regwrite && hits(m.dst, src))
            return 2'b10;
        else if (w.regwrite && hits(w.dst, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // Source fields that the instruction does not read are zeroed, so they
    // can never raise a hazard or select a forward.
    always_comb begin
        id_st     = '0;
        id_src_rs = '0;
        id_src_rt = '0;
        id_beq    = 1'b0;
        case (id_opcode)
            OP_RTYPE: begin
                id_st.dst      = id_rd;
                id_st.regwrite = 1'b1;
                id_src_rs      = id_rs;
                id_src_rt      = id_rt;
            end
            OP_ADDI, OP_ANDI: begin
                id_st.dst      = id_rt;
                id_st.regwrite = 1'b1;
                id_src_rs      = id_rs;
            end
            OP_LW: begin
                id_st.dst      = id_rt;
                id_st.regwrite = 1'b1;
                id_st.memread  = 1'b1;
                id_src_rs      = id_rs;
            end
            OP_SW: begin
                id_src_rs = id_rs;
                id_src_rt = id_rt;
            end
            OP_BEQ: begin
                id_src_rs = id_rs;
                id_src_rt = id_rt;
                id_beq    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_use  = ex_st.memread &&
                    (hits(ex_st.dst, id_src_rs) || hits(ex_st.dst, id_src_rt));
        br_hazard = id_beq &&
                    ((ex_st.regwrite  && (hits(ex_st.dst,  id_src_rs) || hits(ex_st.dst,  id_src_rt))) ||
                     (mem_st.memread  && (hits(mem_st.dst, id_src_rs) || hits(mem_st.dst, id_src_rt))));
    end

    // Priority: reset, memory busy, data/branch hazard, taken branch.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            // outputs stay at their normal-operation values
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (load_use || br_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (id_beq && br_taken) begin
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_st, wb_st);
        fwd_b = fwd_sel(ex_rt, mem_st, wb_st);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_st  <= '0;
            ex_rs  <= '0;
            ex_rt  <= '0;
            mem_st <= '0;
            wb_st  <= '0;
        end else if (!mem_busy) begin
            wb_st  <= mem_st;
            mem_st <= ex_st;
            if (idex_bubble) begin
                ex_st <= '0;
                ex_rs <= '0;
                ex_rt <= '0;
            end else begin
                ex_st <= id_st;
                ex_rs <= id_src_rs;
                ex_rt <= id_src_rt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_count <= '0;
        else if (!pc_write && (stall_count != '1))
            stall_count <= stall_count + 16'd1;
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit -- directed, table-driven bench for hazard_unit.
// Each vector drives the ID inputs, checks the zero-latency outputs and the
// current stall_count, then lets one clock edge advance the shadow pipeline.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  id_opcode = '0;
    logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
    logic        br_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    hazard_unit dut (
        .clk        (clk),
        .rst        (rst),
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .br_taken   (br_taken),
        .mem_busy   (mem_busy),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .idex_bubble(idex_bubble),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'h00, LW = 6'h23, ADDI = 6'h08, BEQ = 6'h04, NOP = 6'h3F;
    // {pc_write, ifid_write, ifid_flush, idex_bubble}
    localparam logic [3:0] N = 4'b1100, S = 4'b0001, B = 4'b0000, F = 4'b1110;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        logic        br, busy;
        logic [3:0]  ctl;
        logic [1:0]  fa, fb;
        logic [15:0] sc;
    } tv_t;

    tv_t tv[$];

    function automatic tv_t v(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic br, input logic busy,
                              input logic [3:0] ctl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [15:0] sc);
        tv_t t;
        t.op = op; t.rs = rs; t.rt = rt; t.rd = rd; t.br = br; t.busy = busy;
        t.ctl = ctl; t.fa = fa; t.fb = fb; t.sc = sc;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic br, input logic busy);
        id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; br_taken = br; mem_busy = busy;
    endtask

    function automatic logic [3:0] ctl_now();
        return {pc_write, ifid_write, ifid_flush, idex_bubble};
    endfunction

    initial begin
        //        op    rs  rt  rd  br busy ctl fa     fb     sc
        tv.push_back(v(LW,   1,  8,  0, 0, 0, N, 2'b00, 2'b00, 0));   // lw $8 enters EX
        tv.push_back(v(R,    8,  2,  9, 0, 0, S, 2'b00, 2'b00, 0));   // load-use stall
        tv.push_back(v(R,    8,  2,  9, 0, 0, N, 2'b00, 2'b00, 1));
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b01, 2'b00, 1));   // reader gets WB forward
        tv.push_back(v(R,    1,  2,  5, 0, 0, N, 2'b00, 2'b00, 1));   // add -> $5
        tv.push_back(v(R,    3,  4,  5, 0, 0, N, 2'b00, 2'b00, 1));   // add -> $5
        tv.push_back(v(R,    5,  5,  6, 0, 0, N, 2'b00, 2'b00, 1));   // reads $5,$5
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b10, 2'b10, 1));   // MEM wins over WB
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b00, 2'b00, 1));
        tv.push_back(v(R,    1,  2,  0, 0, 0, N, 2'b00, 2'b00, 1));   // writes $0
        tv.push_back(v(R,    0,  0,  7, 0, 0, N, 2'b00, 2'b00, 1));   // reads $0
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b00, 2'b00, 1));   // no forward of $0
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b00, 2'b00, 1));
        tv.push_back(v(LW,   1,  0,  0, 0, 0, N, 2'b00, 2'b00, 1));   // lw $0
        tv.push_back(v(R,    0,  0,  3, 0, 0, N, 2'b00, 2'b00, 1));   // no load-use on $0
        tv.push_back(v(ADDI, 1,  3,  0, 0, 0, N, 2'b00, 2'b00, 1));   // addi -> $3
        tv.push_back(v(BEQ,  3,  4,  0, 1, 0, S, 2'b00, 2'b00, 1));   // branch hazard beats taken
        tv.push_back(v(BEQ,  3,  4,  0, 1, 0, F, 2'b00, 2'b00, 2));   // taken -> flush
        tv.push_back(v(NOP,  0,  0,  0, 1, 0, N, 2'b01, 2'b00, 2));   // br_taken ignored off beq
        tv.push_back(v(LW,   0,  4,  0, 0, 0, N, 2'b00, 2'b00, 2));   // lw $4
        tv.push_back(v(BEQ,  1,  4,  0, 0, 0, S, 2'b00, 2'b00, 2));   // lw in EX
        tv.push_back(v(BEQ,  1,  4,  0, 0, 0, S, 2'b00, 2'b00, 3));   // lw in MEM
        tv.push_back(v(BEQ,  1,  4,  0, 0, 0, N, 2'b00, 2'b00, 4));   // not taken
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b00, 2'b00, 4));
        tv.push_back(v(LW,   2,  8,  0, 0, 0, N, 2'b00, 2'b00, 4));   // lw $8
        tv.push_back(v(R,    8,  9, 10, 0, 1, B, 2'b00, 2'b00, 4));   // busy beats load-use
        tv.push_back(v(R,    8,  9, 10, 0, 1, B, 2'b00, 2'b00, 5));
        tv.push_back(v(R,    8,  9, 10, 0, 1, B, 2'b00, 2'b00, 6));
        tv.push_back(v(R,    8,  9, 10, 0, 0, S, 2'b00, 2'b00, 7));   // held state -> stall
        tv.push_back(v(R,    8,  9, 10, 0, 0, N, 2'b00, 2'b00, 8));
        tv.push_back(v(NOP,  0,  0,  0, 0, 0, N, 2'b01, 2'b00, 8));

        // Reset with hazardous-looking inputs: outputs stay normal.
        #1 rst = 1'b1;
        drive(BEQ, 3, 3, 0, 1, 1);
        #1;
        chk("rst_ctl", ctl_now(), N);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("rst_sc", stall_count, 0);
        @(negedge clk); @(negedge clk);
        chk("rst_sc_clocked", stall_count, 0);
        chk("rst_ctl_clocked", ctl_now(), N);
        rst = 1'b0;
        drive(NOP, 0, 0, 0, 0, 0);

        foreach (tv[i]) begin
            drive(tv[i].op, tv[i].rs, tv[i].rt, tv[i].rd, tv[i].br, tv[i].busy);
            #1;
            chk($sformatf("v%0d_ctl", i), ctl_now(), tv[i].ctl);
            chk($sformatf("v%0d_fwd_a", i), fwd_a, tv[i].fa);
            chk($sformatf("v%0d_fwd_b", i), fwd_b, tv[i].fb);
            chk($sformatf("v%0d_sc", i), stall_count, tv[i].sc);
            @(negedge clk);
        end

        // Reset mid-stall: lw $8 in EX, dependent R-type frozen by mem_busy.
        drive(LW, 2, 8, 0, 0, 0);
        @(negedge clk);
        drive(R, 8, 9, 10, 0, 1);
        repeat (8) @(negedge clk);
        #1;
        chk("mid_sc_0x10", stall_count, 16'h0010);
        chk("mid_ctl_busy", ctl_now(), B);
        #1 rst = 1'b1;
        #1;
        chk("async_sc_clear", stall_count, 0);
        chk("async_ctl", ctl_now(), N);
        chk("async_fwd", {fwd_a, fwd_b}, 4'b0000);
        mem_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_no_loaduse", ctl_now(), N);
        chk("post_rst_sc", stall_count, 0);
        @(negedge clk);
        #1;
        chk("post_rst_sc_edge", stall_count, 0);

        // Saturation of stall_count.
        drive(NOP, 0, 0, 0, 0, 1);
        repeat (65535) @(negedge clk);
        #1;
        chk("sat_ffff", stall_count, 16'hFFFF);
        repeat (4) @(negedge clk);
        #1;
        chk("sat_hold", stall_count, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
